// File: rtl/if_fetch.sv
// Instruction fetch stage: issues word-aligned fetch requests, tracks up to two
// outstanding requests, buffers returned instructions in order and discards
// responses that belong to a flushed (redirected or reset) fetch stream.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  logic [31:0] fpc_q, fpc_d;
  logic [31:0] pend_pc_q   [2];
  logic [31:0] pend_pc_d   [2];
  logic [1:0]  pend_cnt_q, pend_cnt_d;
  logic [31:0] buf_pc_q    [2];
  logic [31:0] buf_pc_d    [2];
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_instr_d [2];
  logic [1:0]  buf_cnt_q, buf_cnt_d;
  logic [1:0]  drop_cnt_q, drop_cnt_d;

  logic        pop;
  logic        grant;
  logic        rsp_owned;
  logic        rsp_keep;
  logic [2:0]  credit_used;

  assign valid_out = !reset && (buf_cnt_q != 2'd0);
  assign instr_out = valid_out ? buf_instr_q[0] : NOP_INSTR;
  assign pc_out    = valid_out ? buf_pc_q[0] : 32'h0;
  assign pop       = valid_out && !stall;

  // Credit covers buffered, pending and to-be-dropped entries; an entry leaving the
  // buffer this cycle frees its slot immediately so a zero-wait memory streams
  // one instruction per cycle.
  assign credit_used = {1'b0, buf_cnt_q} + {1'b0, pend_cnt_q} + {1'b0, drop_cnt_q}
                     - {2'b00, pop};
  assign imem_req    = !reset && !redirect && (credit_used < 3'd2);
  assign imem_addr   = fpc_q;
  assign grant       = imem_req && imem_gnt;

  // A response matches some outstanding request; it is kept only when no older
  // dropped requests are ahead of it and no flush happens this cycle.
  assign rsp_owned = imem_rvalid && ((pend_cnt_q != 2'd0) || (drop_cnt_q != 2'd0));
  assign rsp_keep  = imem_rvalid && (drop_cnt_q == 2'd0) && (pend_cnt_q != 2'd0) && !redirect;

  // Next-state: pop, then accept response, then record grant; redirect flushes.
  always_comb begin
    fpc_d      = fpc_q;
    pend_cnt_d = pend_cnt_q;
    buf_cnt_d  = buf_cnt_q;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < 2; i++) begin
      pend_pc_d[i]   = pend_pc_q[i];
      buf_pc_d[i]    = buf_pc_q[i];
      buf_instr_d[i] = buf_instr_q[i];
    end

    if (pop) begin
      buf_pc_d[0]    = buf_pc_q[1];
      buf_instr_d[0] = buf_instr_q[1];
      buf_cnt_d      = buf_cnt_q - 2'd1;
    end

    if (rsp_keep) begin
      buf_pc_d[buf_cnt_d[0]]    = pend_pc_q[0];
      buf_instr_d[buf_cnt_d[0]] = imem_rdata;
      buf_cnt_d                 = buf_cnt_d + 2'd1;
      pend_pc_d[0]              = pend_pc_q[1];
      pend_cnt_d                = pend_cnt_q - 2'd1;
    end else if (imem_rvalid && (drop_cnt_q != 2'd0)) begin
      drop_cnt_d = drop_cnt_q - 2'd1;
    end

    if (grant) begin
      pend_pc_d[pend_cnt_d[0]] = fpc_q;
      pend_cnt_d               = pend_cnt_d + 2'd1;
      fpc_d                    = fpc_q + 32'd4;
    end

    if (redirect) begin
      fpc_d      = {redirect_pc[31:2], 2'b00};
      buf_cnt_d  = 2'd0;
      pend_cnt_d = 2'd0;
      // Every outstanding request becomes a drop; one arriving now is consumed.
      drop_cnt_d = drop_cnt_q + pend_cnt_q - {1'b0, rsp_owned};
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q      <= RESET_PC;
      pend_cnt_q <= 2'd0;
      buf_cnt_q  <= 2'd0;
      drop_cnt_q <= 2'd0;
    end else begin
      fpc_q      <= fpc_d;
      pend_cnt_q <= pend_cnt_d;
      buf_cnt_q  <= buf_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Queue and buffer payloads; meaningful only under their counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pend_pc_q[i]   <= pend_pc_d[i];
      buf_pc_q[i]    <= buf_pc_d[i];
      buf_instr_q[i] <= buf_instr_d[i];
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: in-order memory model with configurable latency, and a
// stream model that predicts fetch addresses and the popped pc/instr sequence.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;

  always #5 clk = ~clk;

  if_fetch #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .valid_out  (valid_out)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int pops  = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit chk_credit = 1'b0;

  logic [31:0] mq_addr [$];
  int          mq_rdy  [$];

  logic [31:0] mdl_fetch;
  logic [31:0] exp_pc;
  logic [31:0] held_pc;
  logic [31:0] held_instr;
  bit          hold_pend;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the models.
  task automatic cycle(input logic rs, input logic st, input logic rd,
                       input logic [31:0] rpc, input int unsigned gp, input int unsigned rp);
    logic grant;
    @(posedge clk);
    #1;
    cyc++;
    reset       = rs;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_gnt    = ($urandom_range(99) < gp);
    if (mq_addr.size() != 0 && mq_rdy[0] <= cyc && $urandom_range(99) < rp) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    @(negedge clk);

    if (rs) begin
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_instr", instr_out, NOP_INSTR);
      chk("rst_pc", pc_out, 32'd0);
    end else begin
      if (rd) chk("req_on_redirect", 32'(imem_req), 32'd0);
      if (imem_req) chk("fetch_addr", imem_addr, mdl_fetch);
      if (hold_pend) begin
        chk("hold_valid", 32'(valid_out), 32'd1);
        chk("hold_pc", pc_out, held_pc);
        chk("hold_instr", instr_out, held_instr);
      end
      if (valid_out) begin
        chk("pc_seq", pc_out, exp_pc);
        chk("instr_data", instr_out, mem_word(exp_pc));
      end else begin
        chk("empty_instr", instr_out, NOP_INSTR);
      end
    end

    grant = imem_req && imem_gnt;
    if (imem_rvalid) begin
      void'(mq_addr.pop_front());
      void'(mq_rdy.pop_front());
    end
    if (grant) begin
      mq_addr.push_back(imem_addr);
      mq_rdy.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    if (chk_credit) chk("outstanding_le2", (mq_addr.size() <= 2) ? 32'd1 : 32'd0, 32'd1);

    hold_pend  = !rs && !rd && valid_out && st;
    held_pc    = pc_out;
    held_instr = instr_out;
    if (rs) begin
      mdl_fetch = RESET_PC;
      exp_pc    = RESET_PC;
    end else if (rd) begin
      mdl_fetch = {rpc[31:2], 2'b00};
      exp_pc    = {rpc[31:2], 2'b00};
    end else begin
      if (grant) mdl_fetch = mdl_fetch + 32'd4;
      if (valid_out && !st) begin
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required $finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int gaps;
    int p0;
    logic [31:0] first_pc;
    logic [31:0] second_pc;
    logic [31:0] first_gaddr;
    int nvalid;

    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mdl_fetch = RESET_PC; exp_pc = RESET_PC; hold_pend = 1'b0;
    held_pc = '0; held_instr = '0;

    // Reset state
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 100, 100);

    // Zero-wait memory: continuous stream after the fill latency
    first = -1; gaps = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 100, 100);
      if (i == 0) begin
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
      end
      if (i == 4) p0 = pops;
      if (valid_out && first < 0) first = i;
      else if (!valid_out && first >= 0) gaps++;
    end
    chk("zw_first_valid_ge2", (first >= 2) ? 32'd1 : 32'd0, 32'd1);
    chk("zw_first_valid_le3", (first >= 0 && first <= 3) ? 32'd1 : 32'd0, 32'd1);
    chk("zw_no_bubble", 32'(gaps), 32'd0);
    chk("zw_pops_last15", 32'(pops - p0), 32'd15);

    // Stall five cycles with the buffer filling: no requests, outputs frozen
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 100, 100);
      if (i >= 1) chk("stall_no_req", 32'(imem_req), 32'd0);
    end
    p0 = pops;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 100, 100);
    chk("stall_resume_pops", (pops - p0 >= 8) ? 32'd1 : 32'd0, 32'd1);

    // Redirect with two pending requests
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 0, 100);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 100, 0);
    chk("redir_two_pending", 32'(mq_addr.size()), 32'd2);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0103, 100, 0);
    first_pc = 32'hDEAD_BEEF; first_gaddr = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 100, 100);
      if (imem_req && imem_gnt && first_gaddr == 32'hDEAD_BEEF) first_gaddr = imem_addr;
      if (valid_out && first_pc == 32'hDEAD_BEEF) first_pc = pc_out;
    end
    chk("redir_fetch_addr", first_gaddr, 32'h0000_0100);
    chk("redir_first_pc", first_pc, 32'h0000_0100);

    // Address wrap at the top of the address space
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 100, 100);
    nvalid = 0; first_pc = 32'hDEAD_BEEF; second_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 100, 100);
      if (valid_out) begin
        if (nvalid == 0) first_pc = pc_out;
        if (nvalid == 1) second_pc = pc_out;
        nvalid++;
      end
    end
    chk("wrap_pc0", first_pc, 32'hFFFF_FFFC);
    chk("wrap_pc1", second_pc, 32'h0000_0000);

    // Reset with two outstanding; late responses must be ignored
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 0, 100);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 100, 0);
    chk("rst_two_outstanding", 32'(mq_addr.size()), 32'd2);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 0, 100);
      chk("rst_stale_ignored", 32'(valid_out), 32'd0);
    end
    chk("rst_stale_returned", 32'(mq_addr.size()), 32'd0);
    first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 100, 100);
      if (valid_out && first_pc == 32'hDEAD_BEEF) first_pc = pc_out;
    end
    chk("rst_first_pc", first_pc, RESET_PC);

    // Random traffic against the stream and memory models
    chk_credit = 1'b1;
    lat_min = 1; lat_max = 3;
    p0 = pops;
    for (int i = 0; i < 10000; i++) begin
      logic st;
      logic rd;
      st = ($urandom_range(99) < 25);
      rd = ($urandom_range(99) < 3);
      cycle(1'b0, st, rd, $urandom, 70, 70);
    end
    chk("rand_progress", (pops - p0 >= 800) ? 32'd1 : 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
